instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/ir_field_decode.sv | 24 ++
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, opcode constants and the
// canonical NOP word loaded into the instruction register on reset.
package riscv_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } fetch_state_e;

    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP        = 7'b0110011;
    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = {12'h000, 5'd0, 3'b000, 5'd0, OP_IMM};

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/ir_field_decode.sv
// Pure combinational slicing of an instruction word into its RV32 fields,
// including the sign-extended I-type immediate.
module ir_field_decode
    import riscv_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [6:0]  opcode_o,
    output logic [4:0]  rd_o,
    output logic [2:0]  funct3_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [6:0]  funct7_o,
    output logic [31:0] imm_i_o
);

    assign opcode_o = ir_i[6:0];
    assign rd_o     = ir_i[11:7];
    assign funct3_o = ir_i[14:12];
    assign rs1_o    = ir_i[19:15];
    assign rs2_o    = ir_i[24:20];
    assign funct7_o = ir_i[31:25];
    assign imm_i_o  = sext12(ir_i[31:20]);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding memory read at a time, with a
// bounded wait for mem_ready and a sticky error state on timeout.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic        pc_wr_en,
    input  logic [31:0] pc_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic [31:0] pc,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [31:0] imm_i,
    output logic        fetch_done,
    output logic        fetch_err,
    output logic        busy
);

    localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] TO_CNT = WW'(TIMEOUT);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;
    logic [31:0]   ir_pc_q, ir_pc_d;
    logic [WW-1:0] wait_q, wait_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSTR;
            ir_pc_q <= RESET_PC;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                // Branch target is word-aligned; a same-cycle fetch sees it via pc_q.
                if (pc_wr_en) pc_d = pc_target & 32'hFFFF_FFFC;
                if (fetch_req) state_d = S_REQ;
            end
            S_REQ: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    ir_pc_d = pc_q;
                    pc_d    = pc_q + 32'd4;
                    wait_d  = '0;
                    state_d = S_DONE;
                end else if (wait_q == TO_CNT) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req    = (state_q == S_REQ);
    assign mem_addr   = pc_q;
    assign fetch_done = (state_q == S_DONE);
    assign fetch_err  = (state_q == S_ERR);
    assign busy       = (state_q != S_IDLE);
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign ir_pc      = ir_pc_q;

    ir_field_decode u_dec (
        .ir_i     (ir_q),
        .opcode_o (opcode),
        .rd_o     (rd),
        .funct3_o (funct3),
        .rs1_o    (rs1),
        .rs2_o    (rs2),
        .funct7_o (funct7),
        .imm_i_o  (imm_i)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboarded bench for instr_fetch: a default instance for fetch, branch and
// timeout behaviour, and a second one with RESET_PC at the top of memory.
module tb_instr_fetch;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] ir_pc;
        logic [31:0] pc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, fetch_req, pc_wr_en, mem_ready;
    logic [31:0] pc_target, mem_rdata;
    logic        mem_req, fetch_done, fetch_err, busy;
    logic [31:0] mem_addr, ir, ir_pc, pc, imm_i;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;

    logic        reset2, fetch_req2, pc_wr_en2, mem_ready2;
    logic [31:0] pc_target2, mem_rdata2;
    logic        mem_req2, fetch_done2, fetch_err2, busy2;
    logic [31:0] mem_addr2, ir2, ir_pc2, pc2, imm_i2;
    logic [6:0]  opcode2, funct72;
    logic [4:0]  rd2, rs12, rs22;
    logic [2:0]  funct32;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb[$];
    logic [31:0] mpc;

    instr_fetch u_dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_wr_en(pc_wr_en),
        .pc_target(pc_target), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ir(ir), .ir_pc(ir_pc),
        .pc(pc), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
        .rs2(rs2), .funct7(funct7), .imm_i(imm_i), .fetch_done(fetch_done),
        .fetch_err(fetch_err), .busy(busy)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk(clk), .reset(reset2), .fetch_req(fetch_req2), .pc_wr_en(pc_wr_en2),
        .pc_target(pc_target2), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ready(mem_ready2), .mem_rdata(mem_rdata2), .ir(ir2), .ir_pc(ir_pc2),
        .pc(pc2), .opcode(opcode2), .rd(rd2), .funct3(funct32), .rs1(rs12),
        .rs2(rs22), .funct7(funct72), .imm_i(imm_i2), .fetch_done(fetch_done2),
        .fetch_err(fetch_err2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Completed fetches are matched against the queue on the falling edge.
    always @(negedge clk) begin
        if (!reset && fetch_done) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_ir", ir, e.ir);
                chk("sb_ir_pc", ir_pc, e.ir_pc);
                chk("sb_pc", pc, e.pc);
            end
        end
    end

    // dly wait cycles before mem_ready; br loads tgt alongside fetch_req;
    // hold keeps fetch_req high through DONE to show it is ignored there.
    task automatic do_fetch(input logic [31:0] rdata, input int dly, input bit br,
                            input logic [31:0] tgt, input bit hold);
        int nreq;
        fetch_req = 1'b1;
        if (br) begin
            pc_wr_en  = 1'b1;
            pc_target = tgt;
            mpc       = tgt & 32'hFFFF_FFFC;
        end
        tick();
        fetch_req = hold;
        pc_wr_en  = 1'b0;
        chk("req_lat", 32'(mem_req), 32'd1);
        nreq = 0;
        for (int i = 0; i < dly; i++) begin
            nreq += int'(mem_req);
            chk("addr_stable", mem_addr, mpc);
            mem_ready = 1'b0;
            pc_wr_en  = 1'b1;
            pc_target = 32'h0000_0800;
            tick();
        end
        pc_wr_en = 1'b0;
        nreq += int'(mem_req);
        chk("addr", mem_addr, mpc);
        mem_ready = 1'b1;
        mem_rdata = rdata;
        sb.push_back('{rdata, mpc, mpc + 32'd4});
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        chk("req_cycles", 32'(nreq), 32'(dly + 1));
        chk("done_lat", 32'(fetch_done), 32'd1);
        chk("req_off", 32'(mem_req), 32'd0);
        mpc = mpc + 32'd4;
        tick();
        chk("done_pulse", 32'(fetch_done), 32'd0);
        chk("back_idle", 32'(busy), 32'd0);
        fetch_req = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; fetch_req = 1'b0; pc_wr_en = 1'b0; pc_target = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        reset2 = 1'b1; fetch_req2 = 1'b0; pc_wr_en2 = 1'b0; pc_target2 = '0;
        mem_ready2 = 1'b0; mem_rdata2 = '0;
        mpc = 32'h0;
        tick(); tick();
        reset = 1'b0; reset2 = 1'b0;

        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0000_0013);
        chk("rst_ir_pc", ir_pc, 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(fetch_done), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // mem_ready outside REQ must not load ir
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        tick(); tick();
        chk("idle_ready_ir", ir, 32'h0000_0013);
        chk("idle_busy", 32'(busy), 32'd0);
        mem_ready = 1'b0;

        // addi x1, x0, 5 with zero wait states
        do_fetch(32'h0050_0093, 0, 1'b0, 32'h0, 1'b0);
        chk("t1_opcode", 32'(opcode), 32'h13);
        chk("t1_rd", 32'(rd), 32'd1);
        chk("t1_imm", imm_i, 32'd5);
        chk("t1_pc", pc, 32'h4);
        chk("t1_ir_pc", ir_pc, 32'h0);

        // addi x2, x0, -1 with 3 wait states, fetch_req held through DONE
        do_fetch(32'hFFF0_0113, 3, 1'b0, 32'h0, 1'b1);
        chk("t2_imm", imm_i, 32'hFFFF_FFFF);
        chk("t2_rd", 32'(rd), 32'd2);
        chk("t2_pc", pc, 32'h8);
        chk("t2_ir_pc", ir_pc, 32'h4);

        // sub x3, x1, x2 fetched from a branch target issued with fetch_req
        do_fetch(32'h4020_81B3, 0, 1'b1, 32'h0000_0102, 1'b0);
        chk("t3_pc", pc, 32'h0000_0104);
        chk("t3_ir_pc", ir_pc, 32'h0000_0100);
        chk("t3_opcode", 32'(opcode), 32'h33);
        chk("t3_funct7", 32'(funct7), 32'h20);
        chk("t3_rs2", 32'(rs2), 32'd2);
        chk("t3_rs1", 32'(rs1), 32'd1);
        chk("t3_funct3", 32'(funct3), 32'd0);
        chk("t3_rd", 32'(rd), 32'd3);

        // plain branch in IDLE, low bits dropped
        pc_wr_en = 1'b1; pc_target = 32'h0000_0203;
        tick();
        pc_wr_en = 1'b0;
        chk("t4_pc", pc, 32'h0000_0200);
        chk("t4_busy", 32'(busy), 32'd0);
        mpc = 32'h0000_0200;

        // memory never answers
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            tick();
        end
        chk("to_cycles", 32'(n), 32'd16);
        chk("to_err", 32'(fetch_err), 32'd1);
        chk("to_busy", 32'(busy), 32'd1);
        chk("to_pc", pc, 32'h0000_0200);
        chk("to_ir", ir, 32'h4020_81B3);
        chk("to_mem_req", 32'(mem_req), 32'd0);
        mem_ready = 1'b1; fetch_req = 1'b1; mem_rdata = 32'h0000_0033;
        tick(); tick(); tick();
        chk("to_sticky", 32'(fetch_err), 32'd1);
        chk("to_sticky_ir", ir, 32'h4020_81B3);
        mem_ready = 1'b0; fetch_req = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("to_rst_err", 32'(fetch_err), 32'd0);
        chk("to_rst_busy", 32'(busy), 32'd0);
        chk("to_rst_pc", pc, 32'h0);
        chk("to_rst_ir", ir, 32'h0000_0013);

        // top-of-memory reset PC: wrap, then reset during REQ
        chk("w_rst_pc", pc2, 32'hFFFF_FFFC);
        chk("w_rst_ir_pc", ir_pc2, 32'hFFFF_FFFC);
        fetch_req2 = 1'b1;
        tick();
        fetch_req2 = 1'b0;
        chk("w_addr", mem_addr2, 32'hFFFF_FFFC);
        mem_ready2 = 1'b1; mem_rdata2 = 32'h00A0_0193;
        tick();
        mem_ready2 = 1'b0;
        chk("w_done", 32'(fetch_done2), 32'd1);
        chk("w_pc", pc2, 32'h0);
        chk("w_ir_pc", ir_pc2, 32'hFFFF_FFFC);
        chk("w_err", 32'(fetch_err2), 32'd0);
        chk("w_imm", imm_i2, 32'd10);
        tick();
        fetch_req2 = 1'b1;
        tick();
        fetch_req2 = 1'b0;
        chk("ab_req", 32'(mem_req2), 32'd1);
        chk("ab_addr", mem_addr2, 32'h0);
        tick();
        reset2 = 1'b1; mem_ready2 = 1'b1; mem_rdata2 = 32'h0000_0033;
        tick();
        reset2 = 1'b0; mem_ready2 = 1'b0;
        chk("ab_mem_req", 32'(mem_req2), 32'd0);
        chk("ab_ir", ir2, 32'h0000_0013);
        chk("ab_pc", pc2, 32'hFFFF_FFFC);
        chk("ab_busy", 32'(busy2), 32'd0);

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
